// File: rtl/qpsk_demod_if.sv
// qpsk_demod_if: sample-in / bit-pair-out bundle of the QPSK demodulator.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. A producer holds its payload stable while
// valid is high and ready is low; ready may depend combinationally on the
// consumer's registered state.
//
// Signals:
//   i_I, i_Q           signed DATA_W samples from the channel/ADC side
//   i_valid            sample valid
//   o_ready_for_input  demodulator can take a sample this cycle
//   o_I, o_Q           decided bit pair
//   o_valid            bit pair valid
//   i_out_ready        downstream accepts the bit pair
//   o_soft_I, o_soft_Q signed 8-bit soft values (only with QPSK_DEMOD_SOFT_EN)
//
// Modports: master = demodulator side, slave = sample source / bit sink.
interface qpsk_demod_if #(
    parameter int DATA_W = 12
);
    logic signed [DATA_W-1:0] i_I;
    logic signed [DATA_W-1:0] i_Q;
    logic                     i_valid;
    logic                     o_ready_for_input;
    logic                     o_I;
    logic                     o_Q;
    logic                     o_valid;
    logic                     i_out_ready;
`ifdef QPSK_DEMOD_SOFT_EN
    logic signed [7:0]        o_soft_I;
    logic signed [7:0]        o_soft_Q;
`endif

    modport master (
        input  i_I, i_Q, i_valid, i_out_ready,
`ifdef QPSK_DEMOD_SOFT_EN
        output o_soft_I, o_soft_Q,
`endif
        output o_ready_for_input, o_I, o_Q, o_valid
    );

    modport slave (
        output i_I, i_Q, i_valid, i_out_ready,
`ifdef QPSK_DEMOD_SOFT_EN
        input  o_soft_I, o_soft_Q,
`endif
        input  o_ready_for_input, o_I, o_Q, o_valid
    );
endinterface

// File: rtl/qpsk_demod.sv
// qpsk_demod: integrate-and-dump QPSK demodulator.
//
// Sums SPS signed I/Q samples per symbol and makes a hard sign decision per
// rail (sum >= 0 -> bit 1). After reset, ALIGN_SKIP samples are discarded
// once to align the symbol window.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   bus        qpsk_demod_if.master (sample input and bit-pair output streams)
//   dbg_state  current FSM state (0 = ALIGN, 1 = INTEGRATE)
//
// Build option: define QPSK_DEMOD_SOFT_EN to add o_soft_I/o_soft_Q, the top
// 8 bits of the window mean, registered together with o_I/o_Q.
module qpsk_demod #(
    parameter int DATA_W     = 12,
    parameter int SPS        = 4,
    parameter int ALIGN_SKIP = 0
) (
    input  logic          clk,
    input  logic          rst,
    qpsk_demod_if.master  bus,
    output logic          dbg_state
);
    localparam int LOG_SPS = $clog2(SPS);
    localparam int CNT_W   = (LOG_SPS > 0) ? LOG_SPS : 1;
    localparam int ACC_W   = DATA_W + LOG_SPS;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SPS - 1);
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'((ALIGN_SKIP > 0) ? ALIGN_SKIP - 1 : 0);

    typedef enum logic {
        ST_ALIGN     = 1'b0,
        ST_INTEGRATE = 1'b1
    } state_t;

    localparam state_t ST_RESET = (ALIGN_SKIP > 0) ? ST_ALIGN : ST_INTEGRATE;

    state_t                   state, state_nx;
    // cnt doubles as the skip counter while aligning and the window position
    // while integrating; the transition to INTEGRATE clears it.
    logic [CNT_W-1:0]         cnt, cnt_nx;
    logic signed [ACC_W-1:0]  acc_i, acc_q, acc_i_nx, acc_q_nx;
    logic signed [ACC_W-1:0]  ext_i, ext_q, sum_i, sum_q;

    logic valid_r, bit_i_r, bit_q_r;
    logic ready, take, last, dump;

    assign ext_i = ACC_W'($signed(bus.i_I));
    assign ext_q = ACC_W'($signed(bus.i_Q));
    assign sum_i = acc_i + ext_i;
    assign sum_q = acc_q + ext_q;

    assign last = (cnt == CNT_LAST);
    // Only the dump sample has to wait for the previous pair to leave.
    assign ready = !(state == ST_INTEGRATE && last && valid_r && !bus.i_out_ready);
    assign take  = bus.i_valid && ready;
    assign dump  = take && (state == ST_INTEGRATE) && last;

    assign bus.o_ready_for_input = ready;
    assign bus.o_valid           = valid_r;
    assign bus.o_I               = bit_i_r;
    assign bus.o_Q               = bit_q_r;
    assign dbg_state             = state;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        acc_i_nx = acc_i;
        acc_q_nx = acc_q;
        if (take) begin
            case (state)
                ST_ALIGN: begin
                    if (cnt == SKIP_LAST) begin
                        state_nx = ST_INTEGRATE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    if (last) begin
                        cnt_nx   = '0;
                        acc_i_nx = '0;
                        acc_q_nx = '0;
                    end else begin
                        cnt_nx   = cnt + 1'b1;
                        acc_i_nx = sum_i;
                        acc_q_nx = sum_q;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RESET;
            cnt   <= '0;
            acc_i <= '0;
            acc_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            acc_i <= acc_i_nx;
            acc_q <= acc_q_nx;
        end
    end

    // A dump in the same cycle as consumption simply reloads the register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            bit_i_r <= 1'b0;
            bit_q_r <= 1'b0;
        end else if (dump) begin
            valid_r <= 1'b1;
            bit_i_r <= ~sum_i[ACC_W-1];
            bit_q_r <= ~sum_q[ACC_W-1];
        end else if (valid_r && bus.i_out_ready) begin
            valid_r <= 1'b0;
        end
    end

`ifdef QPSK_DEMOD_SOFT_EN
    logic signed [ACC_W-1:0] mean_i, mean_q;
    logic signed [7:0]       soft_i_r, soft_q_r;

    // Arithmetic shift by log2(SPS) gives the floor of the window mean.
    assign mean_i = sum_i >>> LOG_SPS;
    assign mean_q = sum_q >>> LOG_SPS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            soft_i_r <= '0;
            soft_q_r <= '0;
        end else if (dump) begin
            soft_i_r <= mean_i[DATA_W-1:DATA_W-8];
            soft_q_r <= mean_q[DATA_W-1:DATA_W-8];
        end
    end

    assign bus.o_soft_I = soft_i_r;
    assign bus.o_soft_Q = soft_q_r;
`endif
endmodule

// File: tb/tb_qpsk_demod.sv
module tb_qpsk_demod;
    localparam int DATA_W = 12;
    localparam int SPS    = 4;
    localparam int SKIP_B = 2;

    logic clk;
    logic rst;
    logic dbg_a, dbg_b;

    qpsk_demod_if #(.DATA_W(DATA_W)) bus_a ();
    qpsk_demod_if #(.DATA_W(DATA_W)) bus_b ();

    qpsk_demod #(.DATA_W(DATA_W), .SPS(SPS), .ALIGN_SKIP(0)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.master), .dbg_state(dbg_a)
    );
    qpsk_demod #(.DATA_W(DATA_W), .SPS(SPS), .ALIGN_SKIP(SKIP_B)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.master), .dbg_state(dbg_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit rnd_mode = 1'b0;

    logic [1:0]  exp_q_a[$];
    logic [1:0]  exp_q_b[$];
    logic [15:0] exp_soft_a[$];
    logic [1:0]  cap_a[$];

    // Reference model: per DUT, skip count then running window sums.
    int skip_left[2];
    int sum_i[2];
    int sum_q[2];
    int n_win[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q_a.delete();
        exp_q_b.delete();
        exp_soft_a.delete();
        skip_left[0] = 0;
        skip_left[1] = SKIP_B;
        for (int d = 0; d < 2; d++) begin
            sum_i[d] = 0;
            sum_q[d] = 0;
            n_win[d] = 0;
        end
    endfunction

    function automatic void model_take(input int d, input int si, input int sq);
        logic [1:0] pair;
        int mi, mq;
        if (skip_left[d] > 0) begin
            skip_left[d]--;
            return;
        end
        sum_i[d] += si;
        sum_q[d] += sq;
        n_win[d]++;
        if (n_win[d] == SPS) begin
            pair = {sum_i[d] >= 0, sum_q[d] >= 0};
            if (d == 0) begin
                exp_q_a.push_back(pair);
                mi = sum_i[d] >>> $clog2(SPS);
                mq = sum_q[d] >>> $clog2(SPS);
                exp_soft_a.push_back({8'((mi >>> (DATA_W - 8)) & 255), 8'((mq >>> (DATA_W - 8)) & 255)});
            end else begin
                exp_q_b.push_back(pair);
            end
            sum_i[d] = 0;
            sum_q[d] = 0;
            n_win[d] = 0;
        end
    endfunction

    // ---------------- driver ----------------
    // Called just after a falling edge; returns just after a falling edge.
    task automatic send(input int d, input int si, input int sq, output int stalls);
        logic rdy;
        bit   done;
        stalls = 0;
        done   = 1'b0;
        if (d == 0) begin
            bus_a.i_I = DATA_W'(si); bus_a.i_Q = DATA_W'(sq); bus_a.i_valid = 1'b1;
        end else begin
            bus_b.i_I = DATA_W'(si); bus_b.i_Q = DATA_W'(sq); bus_b.i_valid = 1'b1;
        end
        for (int c = 0; c < 60 && !done; c++) begin
            #4;
            rdy = (d == 0) ? bus_a.o_ready_for_input : bus_b.o_ready_for_input;
            @(posedge clk);
            if (rdy) begin
                model_take(d, si, sq);
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(negedge clk);
            if (!done && rnd_mode && d == 0) bus_a.i_out_ready = 1'($urandom_range(0, 1));
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: dut %0d never ready for sample", d);
        end
        if (d == 0) bus_a.i_valid = 1'b0;
        else        bus_b.i_valid = 1'b0;
    endtask

    task automatic send_window(input int d, input int si, input int sq);
        int st;
        for (int k = 0; k < SPS; k++) send(d, si, sq, st);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- monitors / scoreboard ----------------
    always begin
        @(negedge clk);
        #4;
        if (!rst && bus_a.o_valid && bus_a.i_out_ready) begin
            if (exp_q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_pair: got %b%b with no expected pair", bus_a.o_I, bus_a.o_Q);
            end else begin
                check("a_pair", 32'({bus_a.o_I, bus_a.o_Q}), 32'(exp_q_a.pop_front()));
`ifdef QPSK_DEMOD_SOFT_EN
                check("a_soft", 32'({bus_a.o_soft_I, bus_a.o_soft_Q}), 32'(exp_soft_a.pop_front()));
`else
                void'(exp_soft_a.pop_front());
`endif
            end
            cap_a.push_back({bus_a.o_I, bus_a.o_Q});
        end
    end

    always begin
        @(negedge clk);
        #4;
        if (!rst && bus_b.o_valid && bus_b.i_out_ready) begin
            if (exp_q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_pair: got %b%b with no expected pair", bus_b.o_I, bus_b.o_Q);
            end else begin
                check("b_pair", 32'({bus_b.o_I, bus_b.o_Q}), 32'(exp_q_b.pop_front()));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int st, st_sum;
        logic [15:0] pat, got_word;

        rst = 1'b1;
        bus_a.i_I = '0; bus_a.i_Q = '0; bus_a.i_valid = 1'b0; bus_a.i_out_ready = 1'b1;
        bus_b.i_I = '0; bus_b.i_Q = '0; bus_b.i_valid = 1'b0; bus_b.i_out_ready = 1'b1;
        model_reset();
        idle(3);
        rst = 1'b0;

        // Reset state
        check("rst_a_valid", 32'(bus_a.o_valid), 0);
        check("rst_a_bits", 32'({bus_a.o_I, bus_a.o_Q}), 0);
        check("rst_a_ready", 32'(bus_a.o_ready_for_input), 1);
        check("rst_b_valid", 32'(bus_b.o_valid), 0);
`ifdef QPSK_DEMOD_SOFT_EN
        check("rst_a_soft", 32'({bus_a.o_soft_I, bus_a.o_soft_Q}), 0);
`endif

        // Basic window and one-cycle latency
        send(0, 1000, -1000, st);
        send(0, 1000, -1000, st);
        send(0, 1000, -1000, st);
        check("basic_no_valid_early", 32'(bus_a.o_valid), 0);
        send(0, 1000, -1000, st);
        check("basic_valid", 32'(bus_a.o_valid), 1);
        check("basic_bits", 32'({bus_a.o_I, bus_a.o_Q}), 32'(2'b10));
`ifdef QPSK_DEMOD_SOFT_EN
        check("basic_soft", 32'({bus_a.o_soft_I, bus_a.o_soft_Q}), 32'(16'h3EC1));
`endif
        idle(2);

        // Bit-sequence round trip, LSB pair first, I = upper bit of the pair
        pat = 16'b1110100101111000;
        cap_a.delete();
        for (int k = 0; k < 8; k++)
            send_window(0, pat[2*k+1] ? 1500 : -1500, pat[2*k] ? 1500 : -1500);
        idle(3);
        check("pattern_count", 32'(cap_a.size()), 8);
        got_word = '0;
        for (int k = 0; k < 8 && k < cap_a.size(); k++) begin
            got_word[2*k+1] = cap_a[k][1];
            got_word[2*k]   = cap_a[k][0];
        end
        check("pattern_word", 32'(got_word), 32'(pat));

        // Zero and extreme windows
        send_window(0, 0, -2048);
        send_window(0, -2048, 0);
        send(0, 2047, 2047, st);
        send(0, 2047, 2047, st);
        send(0, -2048, -2048, st);
        send(0, -2048, -2048, st);
        send_window(0, 2047, -2048);
        idle(3);

        // Random samples, input bubbles, random downstream readiness
        rnd_mode = 1'b1;
        for (int w = 0; w < 24; w++) begin
            for (int s = 0; s < SPS; s++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus_a.i_valid = 1'b0;
                    idle($urandom_range(1, 3));
                end
                bus_a.i_out_ready = ($urandom_range(0, 3) != 0);
                send(0, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, st);
            end
        end
        rnd_mode = 1'b0;
        bus_a.i_out_ready = 1'b1;
        idle(3);
        check("random_drained", 32'(exp_q_a.size()), 0);

        // Backpressure: first pair held, only the dump sample stalls
        bus_a.i_out_ready = 1'b0;
        send_window(0, 1500, -1500);
        st_sum = 0;
        for (int k = 0; k < SPS - 1; k++) begin
            send(0, -1500, 1500, st);
            st_sum += st;
        end
        check("bp_nonfinal_stalls", 32'(st_sum), 0);
        fork
            send(0, -1500, 1500, st);
            begin
                for (int k = 0; k < 3; k++) begin
                    #4;
                    check("bp_ready_low", 32'(bus_a.o_ready_for_input), 0);
                    check("bp_pair_held", 32'({bus_a.o_valid, bus_a.o_I, bus_a.o_Q}), 32'(3'b110));
                    @(negedge clk);
                end
                bus_a.i_out_ready = 1'b1;
            end
        join
        check("bp_dump_stalls", 32'(st), 3);
        check("bp_second_pair_no_bubble", 32'({bus_a.o_valid, bus_a.o_I, bus_a.o_Q}), 32'(3'b101));
        idle(3);

        // Asynchronous reset mid-window with a pending pair
        bus_a.i_out_ready = 1'b0;
        send_window(0, 1500, 1500);
        send(0, 2000, -2000, st);
        send(0, 2000, -2000, st);
        check("pre_rst_valid", 32'(bus_a.o_valid), 1);
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_valid", 32'(bus_a.o_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        bus_a.i_out_ready = 1'b1;
        send_window(0, -10, 10);
        idle(3);
        check("post_rst_drained", 32'(exp_q_a.size()), 0);

        // Alignment skip on the second instance
        send(1, -2000, 2000, st);
        send(1, -2000, 2000, st);
        send_window(1, 300, -300);
        send_window(1, -700, 700);
        idle(3);
        check("b_drained", 32'(exp_q_b.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
